// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with per-register busy bits, optional write bypass,
// optional hardwired-zero R0 and a one-register-per-cycle soft-clear sweep.
module regfile_scoreboard #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned ADDR_W    = $clog2(NUM_REGS),
    parameter bit          BYPASS    = 1'b1,
    parameter bit          ZERO_REG0 = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              LD_REG,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] bus,
    input  logic              RSV,
    input  logic [ADDR_W-1:0] RSV_IDX,
    input  logic [ADDR_W-1:0] SR1_IN,
    input  logic [ADDR_W-1:0] SR2_IN,
    output logic [DATA_W-1:0] SR1_OUT,
    output logic [DATA_W-1:0] SR2_OUT,
    output logic              SR1_BUSY,
    output logic              SR2_BUSY,
    input  logic              CLR_REQ,
    output logic              CLR_BUSY,
    output logic              CLR_DONE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic                r_clr_busy;
    logic                r_clr_done;
    logic                w_clr_busy_d;
    logic                w_clr_done_d;
    logic                w_accept;
    logic                w_wr_en;
    logic                w_rsv_en;
    logic [DATA_W-1:0]   w_sr1_data;
    logic [DATA_W-1:0]   w_sr2_data;
    logic                w_sr1_busy;
    logic                w_sr2_busy;

    // A clear request in IDLE takes priority over any same-cycle write or reserve.
    assign w_accept = ((r_state == S_IDLE) && !CLR_REQ) || (r_state == S_DONE);
    assign w_wr_en  = w_accept && LD_REG && (32'(DR) < NUM_REGS);
    assign w_rsv_en = w_accept && RSV && (32'(RSV_IDX) < NUM_REGS)
                      && !(ZERO_REG0 && (RSV_IDX == '0));

    always_comb begin
        w_state_nxt  = r_state;
        w_clr_busy_d = 1'b0;
        w_clr_done_d = 1'b0;
        case (r_state)
            S_IDLE:  if (CLR_REQ) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_cnt == ADDR_W'(NUM_REGS - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_clr_busy_d = (w_state_nxt == S_CLEAR);
        w_clr_done_d = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= (r_state == S_CLEAR) ? r_cnt + 1'b1 : '0;
            r_clr_busy <= w_clr_busy_d;
            r_clr_done <= w_clr_done_d;
        end
    end

    // Reserve is applied after the write so it wins on a same-index collision.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
            r_busy <= '0;
        end else if (r_state == S_CLEAR) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (r_cnt == ADDR_W'(i)) begin
                    r_regs[i] <= '0;
                    r_busy[i] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_wr_en && (DR == ADDR_W'(i))) begin
                    if (!(ZERO_REG0 && (i == 0))) r_regs[i] <= bus;
                    r_busy[i] <= 1'b0;
                end
                if (w_rsv_en && (RSV_IDX == ADDR_W'(i))) r_busy[i] <= 1'b1;
            end
        end
    end

    // Out-of-range indices match no register and read as zero / not busy.
    always_comb begin
        w_sr1_data = '0;
        w_sr1_busy = 1'b0;
        w_sr2_data = '0;
        w_sr2_busy = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (SR1_IN == ADDR_W'(i)) begin
                w_sr1_data = r_regs[i];
                w_sr1_busy = r_busy[i];
            end
            if (SR2_IN == ADDR_W'(i)) begin
                w_sr2_data = r_regs[i];
                w_sr2_busy = r_busy[i];
            end
        end
        if (BYPASS && w_wr_en && (DR == SR1_IN)) begin
            w_sr1_data = bus;
            w_sr1_busy = 1'b0;
        end
        if (BYPASS && w_wr_en && (DR == SR2_IN)) begin
            w_sr2_data = bus;
            w_sr2_busy = 1'b0;
        end
        if (ZERO_REG0 && (SR1_IN == '0)) begin
            w_sr1_data = '0;
            w_sr1_busy = 1'b0;
        end
        if (ZERO_REG0 && (SR2_IN == '0)) begin
            w_sr2_data = '0;
            w_sr2_busy = 1'b0;
        end
    end

    assign SR1_OUT  = w_sr1_data;
    assign SR2_OUT  = w_sr2_data;
    assign SR1_BUSY = w_sr1_busy;
    assign SR2_BUSY = w_sr2_busy;
    assign CLR_BUSY = r_clr_busy;
    assign CLR_DONE = r_clr_done;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two configurations driven in lockstep and checked
// against a behavioural model of register contents, busy bits and sweep progress.
module tb_regfile_scoreboard;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        LD_REG;
    logic [2:0]  DR;
    logic [15:0] bus;
    logic        RSV;
    logic [2:0]  RSV_IDX;
    logic [2:0]  SR1_IN;
    logic [2:0]  SR2_IN;
    logic        CLR_REQ;

    logic [15:0] sr1_out [2];
    logic [15:0] sr2_out [2];
    logic        sr1_busy[2];
    logic        sr2_busy[2];
    logic        clr_busy[2];
    logic        clr_done[2];

    int n_total = 0;
    int n_bad   = 0;

    // Configuration of each instance: register count, bypass, zero-R0.
    int kN  [2] = '{8, 6};
    bit kByp[2] = '{1'b1, 1'b0};
    bit kZ  [2] = '{1'b0, 1'b1};

    // Model: contents, busy flags, phase (0 idle, 1 sweeping, 2 done) and sweep position.
    logic [15:0] m_reg [2][8];
    bit          m_busy[2][8];
    int          m_ph  [2];
    int          m_pos [2];

    always #5 Clk = ~Clk;

    regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .BYPASS(1'b1), .ZERO_REG0(1'b0)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .LD_REG(LD_REG), .DR(DR), .bus(bus),
        .RSV(RSV), .RSV_IDX(RSV_IDX), .SR1_IN(SR1_IN), .SR2_IN(SR2_IN),
        .SR1_OUT(sr1_out[0]), .SR2_OUT(sr2_out[0]),
        .SR1_BUSY(sr1_busy[0]), .SR2_BUSY(sr2_busy[0]),
        .CLR_REQ(CLR_REQ), .CLR_BUSY(clr_busy[0]), .CLR_DONE(clr_done[0])
    );

    regfile_scoreboard #(.DATA_W(16), .NUM_REGS(6), .BYPASS(1'b0), .ZERO_REG0(1'b1)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .LD_REG(LD_REG), .DR(DR), .bus(bus),
        .RSV(RSV), .RSV_IDX(RSV_IDX), .SR1_IN(SR1_IN), .SR2_IN(SR2_IN),
        .SR1_OUT(sr1_out[1]), .SR2_OUT(sr2_out[1]),
        .SR1_BUSY(sr1_busy[1]), .SR2_BUSY(sr2_busy[1]),
        .CLR_REQ(CLR_REQ), .CLR_BUSY(clr_busy[1]), .CLR_DONE(clr_done[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 8; r++) begin
                m_reg[k][r]  = 16'h0;
                m_busy[k][r] = 1'b0;
            end
            m_ph[k]  = 0;
            m_pos[k] = 0;
        end
    endtask

    function automatic bit wr_taken(input int k);
        return LD_REG && (int'(DR) < kN[k]) && ((m_ph[k] == 2) || ((m_ph[k] == 0) && !CLR_REQ));
    endfunction

    task automatic exp_read(input int k, input logic [2:0] idx, output logic [15:0] d, output bit b);
        d = 16'h0;
        b = 1'b0;
        if (kZ[k] && (idx == 3'd0)) begin
            d = 16'h0;
        end else if (int'(idx) >= kN[k]) begin
            d = 16'h0;
        end else if (kByp[k] && wr_taken(k) && (DR == idx)) begin
            d = bus;
        end else begin
            d = m_reg[k][idx];
            b = m_busy[k][idx];
        end
    endtask

    task automatic apply_wr_rsv(input int k);
        if (LD_REG && (int'(DR) < kN[k])) begin
            if (!(kZ[k] && (DR == 3'd0))) m_reg[k][DR] = bus;
            m_busy[k][DR] = 1'b0;
        end
        if (RSV && (int'(RSV_IDX) < kN[k]) && !(kZ[k] && (RSV_IDX == 3'd0)))
            m_busy[k][RSV_IDX] = 1'b1;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            case (m_ph[k])
                0: begin
                    if (CLR_REQ) begin
                        m_ph[k]  = 1;
                        m_pos[k] = 0;
                    end else begin
                        apply_wr_rsv(k);
                    end
                end
                1: begin
                    m_reg[k][m_pos[k]]  = 16'h0;
                    m_busy[k][m_pos[k]] = 1'b0;
                    m_pos[k]++;
                    if (m_pos[k] == kN[k]) m_ph[k] = 2;
                end
                default: begin
                    apply_wr_rsv(k);
                    m_ph[k] = 0;
                end
            endcase
        end
    endtask

    task automatic check(input string tag);
        logic [15:0] d;
        bit          b;
        for (int k = 0; k < 2; k++) begin
            exp_read(k, SR1_IN, d, b);
            chk($sformatf("%s.%0d.sr1_out", tag, k), 32'(sr1_out[k]), 32'(d));
            chk($sformatf("%s.%0d.sr1_busy", tag, k), 32'(sr1_busy[k]), 32'(b));
            exp_read(k, SR2_IN, d, b);
            chk($sformatf("%s.%0d.sr2_out", tag, k), 32'(sr2_out[k]), 32'(d));
            chk($sformatf("%s.%0d.sr2_busy", tag, k), 32'(sr2_busy[k]), 32'(b));
            chk($sformatf("%s.%0d.clr_busy", tag, k), 32'(clr_busy[k]), 32'(m_ph[k] == 1));
            chk($sformatf("%s.%0d.clr_done", tag, k), 32'(clr_done[k]), 32'(m_ph[k] == 2));
        end
    endtask

    // Inputs are set just after a falling edge; compare, then advance one rising edge.
    task automatic cyc(input string tag);
        #1 check(tag);
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    initial begin
        Reset_n = 1'b0;
        LD_REG  = 1'b0; DR = 3'd0; bus = 16'h0;
        RSV     = 1'b0; RSV_IDX = 3'd0;
        SR1_IN  = 3'd0; SR2_IN = 3'd0;
        CLR_REQ = 1'b0;
        model_reset();

        // Reset state over every index
        @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            SR1_IN = 3'(i);
            SR2_IN = 3'(7 - i);
            #1 check("reset");
        end
        Reset_n = 1'b1;

        // Same-cycle write/read of R3
        LD_REG = 1'b1; DR = 3'd3; bus = 16'hBEEF; SR1_IN = 3'd3; SR2_IN = 3'd2;
        cyc("bypass");
        LD_REG = 1'b0;
        cyc("bypass_next");

        // Reserve, write-clears-busy, write+reserve collision on R5
        RSV = 1'b1; RSV_IDX = 3'd5; SR2_IN = 3'd5;
        cyc("rsv5");
        RSV = 1'b0;
        cyc("rsv5_held");
        LD_REG = 1'b1; DR = 3'd5; bus = 16'h1234;
        cyc("wr5");
        LD_REG = 1'b0;
        cyc("wr5_after");
        LD_REG = 1'b1; RSV = 1'b1; bus = 16'h5678;
        cyc("wr_rsv5");
        LD_REG = 1'b0; RSV = 1'b0;
        cyc("wr_rsv5_after");

        // R0 write/reserve and out-of-range index on the 6-register instance
        LD_REG = 1'b1; DR = 3'd0; bus = 16'hFFFF; SR1_IN = 3'd0; SR2_IN = 3'd7;
        cyc("wr_r0");
        DR = 3'd7; bus = 16'h7777; SR1_IN = 3'd7; SR2_IN = 3'd0;
        cyc("wr_r7");
        LD_REG = 1'b0; RSV = 1'b1; RSV_IDX = 3'd0;
        cyc("rsv_r0");
        RSV_IDX = 3'd7;
        cyc("rsv_r7");
        RSV = 1'b0;
        cyc("idx_after");

        // Fill then sweep, with writes and reserves offered throughout
        for (int i = 0; i < 8; i++) begin
            LD_REG = 1'b1; DR = 3'(i); bus = 16'(32'h1111 * i);
            cyc("fill");
        end
        LD_REG = 1'b1; DR = 3'd2; bus = 16'hABCD; CLR_REQ = 1'b1;
        cyc("clr_req");
        CLR_REQ = 1'b0;
        for (int j = 0; j < 12; j++) begin
            LD_REG = 1'b1; DR = 3'(j % 8); bus = 16'($urandom);
            RSV = 1'($urandom_range(1)); RSV_IDX = 3'($urandom_range(7));
            SR1_IN = 3'(j % 8); SR2_IN = 3'((j + 1) % 8);
            cyc("sweep");
        end
        LD_REG = 1'b0; RSV = 1'b0;
        cyc("sweep_idle");

        // Reset asserted in the third sweep cycle
        for (int i = 0; i < 8; i++) begin
            LD_REG = 1'b1; DR = 3'(i); bus = 16'(32'h2222 + i);
            cyc("refill");
        end
        LD_REG = 1'b0; CLR_REQ = 1'b1;
        cyc("clr_req2");
        CLR_REQ = 1'b0;
        for (int j = 0; j < 2; j++) cyc("sweep2");
        SR1_IN = 3'd6; SR2_IN = 3'd7;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_now");
        @(posedge Clk);
        @(negedge Clk);
        check("arst_held");
        Reset_n = 1'b1;
        LD_REG = 1'b1; DR = 3'd4; bus = 16'h4444; SR1_IN = 3'd4;
        cyc("post_rst_wr");
        LD_REG = 1'b0;
        cyc("post_rst_rd");

        // Random traffic, including occasional sweeps
        for (int j = 0; j < 400; j++) begin
            LD_REG  = 1'($urandom_range(1));
            DR      = 3'($urandom_range(7));
            bus     = 16'($urandom);
            RSV     = ($urandom_range(3) == 0);
            RSV_IDX = 3'($urandom_range(7));
            SR1_IN  = 3'($urandom_range(7));
            SR2_IN  = ($urandom_range(3) == 0) ? DR : 3'($urandom_range(7));
            CLR_REQ = ($urandom_range(15) == 0);
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
